// File: rtl/seq_det_event_counter.sv
// seq_det_event_counter
//
// Windowed event counter placed directly after an overlapping "111" sequence
// detector. While enabled it samples the detector bit on every clock, adds up
// events over a window of WINDOW samples, and at each window end offers the
// saturated count to a consumer through a valid/ready handshake. A window
// result that cannot be handed over because the previous report is still
// pending is dropped and flagged on the sticky ovf output.
//
// Build option:
//   SEQ_DET_EDGE_COUNT_EN  defined   -> count rising edges of det_in
//                                       (one event per run of 1s)
//                          undefined -> count every cycle with det_in = 1
//
// Parameters:
//   WINDOW  sampled cycles per window (>= 2)
//   CNT_W   width of the accumulator and of the reported count
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   en         run enable (1 = counting, 0 = idle)
//   det_in     detector output bit
//   cnt_out    count of the last completed window, stable while cnt_valid = 1
//   cnt_valid  report available
//   cnt_ready  consumer accepts the report
//   sat        reported count saturated (qualified by cnt_valid)
//   ovf        sticky, a window result was dropped

module seq_det_event_counter #(
   parameter int WINDOW = 16,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             det_in,
   output logic [CNT_W-1:0] cnt_out,
   output logic             cnt_valid,
   input  logic             cnt_ready,
   output logic             sat,
   output logic             ovf
);

   localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] ACC_MAX  = '1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic             acc_sat_q, acc_sat_d;
   logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
   logic             cnt_valid_q, cnt_valid_d;
   logic             sat_q, sat_d;
   logic             ovf_q, ovf_d;

   logic             event_term;
   logic [CNT_W-1:0] acc_sum;
   logic             sum_sat;
   logic             win_end;
   logic             handoff;

`ifdef SEQ_DET_EDGE_COUNT_EN
   logic prev_q, prev_d;

   // Edge mode: an event is a 0->1 transition of the detector output, so a
   // sustained run of detections counts once. prev is cleared on entry to
   // RUN, which makes a 1 on the very first sample count as an event.
   always_comb begin
      event_term = det_in & ~prev_q;
      prev_d     = prev_q;
      if (state_q == ST_IDLE) begin
         prev_d = 1'b0;
      end else if (en) begin
         prev_d = det_in;
      end else begin
         prev_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end
`else
   // Level mode: every sampled cycle with det_in high is an event, so
   // overlapping detections count once per cycle.
   always_comb begin
      event_term = det_in;
   end
`endif

   // Saturating accumulate. acc_sat remembers that some addition in the
   // current window was clamped, so the reported sat bit reflects the whole
   // window rather than only its last sample.
   always_comb begin
      if (acc_q == ACC_MAX) begin
         acc_sum = acc_q;
         sum_sat = acc_sat_q | event_term;
      end else begin
         acc_sum = acc_q + {{(CNT_W-1){1'b0}}, event_term};
         sum_sat = acc_sat_q;
      end
      win_end = (state_q == ST_RUN) && en && (win_cnt_q == WIN_LAST);
      handoff = cnt_valid_q & cnt_ready;
   end

   // Run/idle control and window bookkeeping. The entry edge into RUN does
   // not sample det_in; every following enabled edge is one sample. At the
   // window end the accumulator restarts at zero on the same edge so the next
   // window follows without a gap. Dropping en discards the partial window.
   always_comb begin
      state_d   = state_q;
      win_cnt_d = win_cnt_q;
      acc_d     = acc_q;
      acc_sat_d = acc_sat_q;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d   = ST_RUN;
               win_cnt_d = '0;
               acc_d     = '0;
               acc_sat_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (!en) begin
               state_d   = ST_IDLE;
               win_cnt_d = '0;
               acc_d     = '0;
               acc_sat_d = 1'b0;
            end else if (win_end) begin
               win_cnt_d = '0;
               acc_d     = '0;
               acc_sat_d = 1'b0;
            end else begin
               win_cnt_d = win_cnt_q + WIN_W'(1);
               acc_d     = acc_sum;
               acc_sat_d = sum_sat;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            win_cnt_d = '0;
            acc_d     = '0;
            acc_sat_d = 1'b0;
         end
      endcase
   end

   // Output slot. A transfer empties the slot; a window end fills it when it
   // is empty or being emptied on this same edge, otherwise the new result
   // is lost and ovf latches. cnt_out is left untouched by a transfer.
   always_comb begin
      cnt_out_d   = cnt_out_q;
      cnt_valid_d = cnt_valid_q;
      sat_d       = sat_q;
      ovf_d       = ovf_q;
      if (handoff) begin
         cnt_valid_d = 1'b0;
         sat_d       = 1'b0;
      end
      if (win_end) begin
         if (!cnt_valid_q || handoff) begin
            cnt_out_d   = acc_sum;
            sat_d       = sum_sat;
            cnt_valid_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   // All state, asynchronously cleared by the active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         win_cnt_q   <= '0;
         acc_q       <= '0;
         acc_sat_q   <= 1'b0;
         cnt_out_q   <= '0;
         cnt_valid_q <= 1'b0;
         sat_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_cnt_q   <= win_cnt_d;
         acc_q       <= acc_d;
         acc_sat_q   <= acc_sat_d;
         cnt_out_q   <= cnt_out_d;
         cnt_valid_q <= cnt_valid_d;
         sat_q       <= sat_d;
         ovf_q       <= ovf_d;
      end
   end

   assign cnt_out   = cnt_out_q;
   assign cnt_valid = cnt_valid_q;
   assign sat       = sat_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_det_event_counter.sv
// tb_seq_det_event_counter
//
// Self-checking bench for seq_det_event_counter. A main instance uses
// WINDOW=16, CNT_W=8; a second instance with CNT_W=4 exercises saturation.
// Window results predicted by a behavioural model are queued when the last
// sample of a window is driven and compared when the consumer takes them.

module tb_seq_det_event_counter;

   localparam int WINDOW  = 16;
   localparam int CNT_MAX = 255;

`ifdef SEQ_DET_EDGE_COUNT_EN
   localparam int EXP_STEADY = 1;
   localparam int EXP_PAT    = 6;
   localparam int WINDOW_S   = 40;
`else
   localparam int EXP_STEADY = 16;
   localparam int EXP_PAT    = 11;
   localparam int WINDOW_S   = 20;
`endif
   localparam int EXP_ALT = 8;

   typedef struct packed {
      logic [7:0] cnt;
      logic       sat;
   } report_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       det_in = 1'b0;
   logic       cnt_ready = 1'b0;
   logic [7:0] cnt_out;
   logic       cnt_valid;
   logic       sat;
   logic       ovf;

   logic       en_s = 1'b0;
   logic       det_s = 1'b0;
   logic       ready_s = 1'b0;
   logic [3:0] cnt_out_s;
   logic       valid_s;
   logic       sat_s;
   logic       ovf_s;

   int n_checks = 0;
   int n_errors = 0;

   report_t sb[$];
   logic    m_run = 1'b0;
   int      m_idx = 0;
   int      m_cnt = 0;
   logic    m_prev = 1'b0;
   logic    m_ovf = 1'b0;

   always #5 clk = ~clk;

   seq_det_event_counter #(.WINDOW(WINDOW), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .det_in(det_in),
      .cnt_out(cnt_out), .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
      .sat(sat), .ovf(ovf)
   );

   seq_det_event_counter #(.WINDOW(WINDOW_S), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .en(en_s), .det_in(det_s),
      .cnt_out(cnt_out_s), .cnt_valid(valid_s), .cnt_ready(ready_s),
      .sat(sat_s), .ovf(ovf_s)
   );

   // One clock of the main instance: drive inputs at the falling edge,
   // score a handshake transfer, advance the model, then settle after the
   // rising edge.
   task automatic step(input logic e, input logic d, input logic r);
      report_t exp_r;
      logic    ev;
      @(negedge clk);
      en = e;
      det_in = d;
      cnt_ready = r;
      if (r && sb.size() != 0) begin
         exp_r = sb.pop_front();
         n_checks++;
         if (cnt_valid !== 1'b1 || cnt_out !== exp_r.cnt || sat !== exp_r.sat) begin
            n_errors++;
            $display("[TB] FAIL transfer: got valid=%b cnt=%0d sat=%b, expected valid=1 cnt=%0d sat=%b",
                     cnt_valid, cnt_out, sat, exp_r.cnt, exp_r.sat);
         end
      end
      if (!m_run) begin
         if (e) begin
            m_run = 1'b1;
            m_idx = 0;
            m_cnt = 0;
            m_prev = 1'b0;
         end
      end else if (!e) begin
         m_run = 1'b0;
      end else begin
`ifdef SEQ_DET_EDGE_COUNT_EN
         ev = d & ~m_prev;
`else
         ev = d;
`endif
         m_prev = d;
         m_cnt = m_cnt + (ev ? 1 : 0);
         if (m_idx == WINDOW - 1) begin
            exp_r.cnt = (m_cnt > CNT_MAX) ? 8'(CNT_MAX) : 8'(m_cnt);
            exp_r.sat = (m_cnt > CNT_MAX);
            if (sb.size() == 0) sb.push_back(exp_r);
            else m_ovf = 1'b1;
            m_idx = 0;
            m_cnt = 0;
         end else begin
            m_idx++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      en = 1'b0; det_in = 1'b0; cnt_ready = 1'b0;
      en_s = 1'b0; det_s = 1'b0; ready_s = 1'b0;
      repeat (2) @(negedge clk);
      sb.delete();
      m_run = 1'b0; m_idx = 0; m_cnt = 0; m_prev = 1'b0; m_ovf = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         en = 1'($urandom_range(0, 1));
         det_in = 1'($urandom_range(0, 1));
         cnt_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         n_checks++;
         if (cnt_out !== 8'd0 || cnt_valid !== 1'b0 || sat !== 1'b0 || ovf !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_hold: got cnt=%0d valid=%b sat=%b ovf=%b, expected all 0",
                     cnt_out, cnt_valid, sat, ovf);
         end
      end
      @(negedge clk);
      en = 1'b0; det_in = 1'b0; cnt_ready = 1'b0;
      sb.delete();
      m_run = 1'b0; m_ovf = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      n_checks++;
      if (cnt_out !== 8'd0 || cnt_valid !== 1'b0 || sat !== 1'b0 || ovf !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL reset_release_idle: got cnt=%0d valid=%b sat=%b ovf=%b, expected all 0",
                  cnt_out, cnt_valid, sat, ovf);
      end
   endtask

   task automatic test_steady();
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (i == 14) begin
            n_checks++;
            if (cnt_valid !== 1'b0) begin
               n_errors++;
               $display("[TB] FAIL steady_early: got valid=%b after E15, expected 0", cnt_valid);
            end
         end
      end
      n_checks++;
      if (cnt_valid !== 1'b1 || cnt_out !== 8'(EXP_STEADY) || sat !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL steady_report: got valid=%b cnt=%0d sat=%b, expected valid=1 cnt=%0d sat=0",
                  cnt_valid, cnt_out, sat, EXP_STEADY);
      end
      step(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (cnt_valid !== 1'b0 || sat !== 1'b0 || cnt_out !== 8'(EXP_STEADY)) begin
         n_errors++;
         $display("[TB] FAIL steady_after_accept: got valid=%b sat=%b cnt=%0d, expected valid=0 sat=0 cnt=%0d",
                  cnt_valid, sat, cnt_out, EXP_STEADY);
      end
   endtask

   task automatic test_pattern();
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 32; i++) begin
         step(1'b1, (i % 3) != 2, i == 20);
         if (i == 15) begin
            n_checks++;
            if (cnt_valid !== 1'b1 || cnt_out !== 8'(EXP_PAT)) begin
               n_errors++;
               $display("[TB] FAIL pattern_first: got valid=%b cnt=%0d, expected valid=1 cnt=%0d",
                        cnt_valid, cnt_out, EXP_PAT);
            end
         end
         if (i == 20) begin
            n_checks++;
            if (cnt_valid !== 1'b0) begin
               n_errors++;
               $display("[TB] FAIL pattern_accept: got valid=%b, expected 0", cnt_valid);
            end
         end
      end
      n_checks++;
      if (sb.size() != 1) begin
         n_errors++;
         $display("[TB] FAIL pattern_second_queue: got %0d queued reports, expected 1", sb.size());
      end else if (cnt_valid !== 1'b1 || cnt_out !== sb[0].cnt || ovf !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL pattern_second: got valid=%b cnt=%0d ovf=%b, expected valid=1 cnt=%0d ovf=0",
                  cnt_valid, cnt_out, ovf, sb[0].cnt);
      end
      step(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_back_pressure();
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 48; i++) begin
         if (i < 16) step(1'b1, 1'b1, 1'b0);
         else if (i < 32) step(1'b1, 1'b0, 1'b0);
         else step(1'b1, (i % 2) == 1, i == 47);
         if (i == 15 || i == 31) begin
            n_checks++;
            if (cnt_valid !== 1'b1 || cnt_out !== 8'(EXP_STEADY) || ovf !== (i == 31)) begin
               n_errors++;
               $display("[TB] FAIL backpressure_hold_%0d: got valid=%b cnt=%0d ovf=%b, expected valid=1 cnt=%0d ovf=%b",
                        i + 1, cnt_valid, cnt_out, ovf, EXP_STEADY, i == 31);
            end
         end
      end
      n_checks++;
      if (cnt_valid !== 1'b1 || cnt_out !== 8'(EXP_ALT) || ovf !== 1'b1 || ovf !== m_ovf) begin
         n_errors++;
         $display("[TB] FAIL backpressure_replace: got valid=%b cnt=%0d ovf=%b, expected valid=1 cnt=%0d ovf=1",
                  cnt_valid, cnt_out, ovf, EXP_ALT);
      end
      step(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (cnt_valid !== 1'b0 || ovf !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL backpressure_drain: got valid=%b ovf=%b, expected valid=0 ovf=1", cnt_valid, ovf);
      end
   endtask

   task automatic test_abort();
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (cnt_valid !== 1'b0 || sb.size() != 0) begin
         n_errors++;
         $display("[TB] FAIL abort_no_report: got valid=%b, expected 0", cnt_valid);
      end
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (i == 14) begin
            n_checks++;
            if (cnt_valid !== 1'b0) begin
               n_errors++;
               $display("[TB] FAIL abort_restart_early: got valid=%b after E15, expected 0", cnt_valid);
            end
         end
      end
      n_checks++;
      if (cnt_valid !== 1'b1 || cnt_out !== 8'(EXP_STEADY)) begin
         n_errors++;
         $display("[TB] FAIL abort_restart: got valid=%b cnt=%0d, expected valid=1 cnt=%0d",
                  cnt_valid, cnt_out, EXP_STEADY);
      end
      step(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_async_reset();
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 36; i++) step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (cnt_valid !== 1'b1 || ovf !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL async_setup: got valid=%b ovf=%b, expected valid=1 ovf=1", cnt_valid, ovf);
      end
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      n_checks++;
      if (cnt_out !== 8'd0 || cnt_valid !== 1'b0 || sat !== 1'b0 || ovf !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL async_reset: got cnt=%0d valid=%b sat=%b ovf=%b, expected all 0",
                  cnt_out, cnt_valid, sat, ovf);
      end
      @(negedge clk);
      en = 1'b0; det_in = 1'b0;
      sb.delete();
      m_run = 1'b0; m_ovf = 1'b0;
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_saturation();
      do_reset();
      @(negedge clk);
      en_s = 1'b1;
      ready_s = 1'b0;
      for (int i = 0; i < WINDOW_S; i++) begin
         @(negedge clk);
`ifdef SEQ_DET_EDGE_COUNT_EN
         det_s = (i % 2) == 0;
`else
         det_s = 1'b1;
`endif
         if (i == WINDOW_S - 1) begin
            n_checks++;
            if (valid_s !== 1'b0) begin
               n_errors++;
               $display("[TB] FAIL sat_early: got valid=%b before last sample, expected 0", valid_s);
            end
         end
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (valid_s !== 1'b1 || cnt_out_s !== 4'd15 || sat_s !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL sat_report: got valid=%b cnt=%0d sat=%b, expected valid=1 cnt=15 sat=1",
                  valid_s, cnt_out_s, sat_s);
      end
      @(negedge clk);
      en_s = 1'b0;
      det_s = 1'b0;
      ready_s = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (valid_s !== 1'b0 || sat_s !== 1'b0 || cnt_out_s !== 4'd15) begin
         n_errors++;
         $display("[TB] FAIL sat_accept: got valid=%b sat=%b cnt=%0d, expected valid=0 sat=0 cnt=15",
                  valid_s, sat_s, cnt_out_s);
      end
      @(negedge clk);
      ready_s = 1'b0;
   endtask

   initial begin
      $display("[TB] seq_det_event_counter bench start");
      test_reset();
      test_steady();
      test_pattern();
      test_back_pressure();
      test_abort();
      test_async_reset();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
